// File: rtl/interval_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// interval_sequencer_pkg
// Shared definitions for the interval sequencer and its prescaler.
// Holds the 2-bit FSM state encoding used by interval_sequencer:
//   IDLE=0, RUN=1, PAUSED=2, DONE=3
// No ports (package only).
// ---------------------------------------------------------------------------
package interval_sequencer_pkg;

  localparam int STATE_BITS = 2;

  // The numeric values are fixed so that anything decoding the state
  // register (debug taps, waveform viewers) sees a stable encoding.
  typedef enum logic [STATE_BITS-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } seqState_t;

endpackage : interval_sequencer_pkg

// File: rtl/interval_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-PRESCALE counter that advances only while enabled and
// emits a carry-out on the cycle it would wrap.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, clears the count
//   en   - count enable
//   clr  - synchronous clear, wins over en
//   co   - combinational carry-out: en high and count at PRESCALE-1
// Parameters:
//   PRESCALE - modulus (>= 2)
//   PS_BITS  - counter width, 2^PS_BITS >= PRESCALE
// ---------------------------------------------------------------------------
import interval_sequencer_pkg::*;

module tick_prescaler #(
  parameter int PRESCALE = 16,
  parameter int PS_BITS  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic co
);

  localparam logic [PS_BITS-1:0] LAST_COUNT = PS_BITS'(PRESCALE - 1);

  logic [PS_BITS-1:0] r_count;
  logic               w_atLast;

  // The carry-out is combinational so the owner sees the tick in the same
  // cycle the counter sits on its last value, and a disabled counter can
  // never produce a tick even when parked on the last value.
  always_comb begin
    w_atLast = (r_count == LAST_COUNT);
    co       = en && w_atLast;
  end

  // Counter register: reset, then clear, then enabled count with wrap.
  // Clear outranks enable so a restart always begins from a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (w_atLast) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + PS_BITS'(1);
      end
    end
  end

endmodule : tick_prescaler

// File: rtl/interval_sequencer.sv
// ---------------------------------------------------------------------------
// interval_sequencer
// Times an interval of 'period' prescaler ticks. A start in IDLE loads the
// tick count and runs until it reaches zero, then pulses done for one cycle.
// The interval can be frozen with pause or abandoned with stop.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset, highest priority
//   start     - begin an interval (accepted only in IDLE)
//   stop      - abort the current interval, no done
//   pause     - level, freezes prescaler and count while high
//   period    - tick count, captured only when start is accepted
//   busy      - high in RUN or PAUSED
//   done      - one-cycle pulse on normal completion
//   tick      - one-cycle pulse per completed prescaler period
//   remaining - ticks still to go
// Parameters:
//   PRESCALE - prescaler modulus (>= 2)
//   PS_BITS  - prescaler width, 2^PS_BITS >= PRESCALE
//   CNT_BITS - width of period / remaining
// ---------------------------------------------------------------------------
import interval_sequencer_pkg::*;

module interval_sequencer #(
  parameter int PRESCALE = 16,
  parameter int PS_BITS  = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [CNT_BITS-1:0] period,
  output logic                busy,
  output logic                done,
  output logic                tick,
  output logic [CNT_BITS-1:0] remaining
);

  seqState_t           r_state;
  seqState_t           w_nextState;
  logic [CNT_BITS-1:0] r_remaining;
  logic                w_psEn;
  logic                w_psClr;
  logic                w_tick;
  logic                w_active;
  logic                w_accept;
  logic                w_abort;

  // Prescaler instance; its carry-out is the interval tick.
  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_BITS  (PS_BITS)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (w_psEn),
    .clr (w_psClr),
    .co  (w_tick)
  );

  // Control decode. The prescaler only runs in RUN with neither stop nor
  // pause present, which is what gives stop and pause priority over a tick
  // landing in the same cycle. It is cleared on an accepted start (so the
  // first RUN cycle sees count 0) and on an abort (so nothing carries over).
  always_comb begin
    w_active = (r_state == RUN) || (r_state == PAUSED);
    w_accept = (r_state == IDLE) && start;
    w_abort  = w_active && stop;
    w_psEn   = (r_state == RUN) && !stop && !pause;
    w_psClr  = w_accept || w_abort;
  end

  // Next-state logic. Priority inside RUN is stop, then pause, then the
  // final tick. DONE is a single-cycle state that ignores all inputs.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (period != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (stop) begin
          w_nextState = IDLE;
        end else if (pause) begin
          w_nextState = PAUSED;
        end else if (w_tick && (r_remaining == CNT_BITS'(1))) begin
          w_nextState = DONE;
        end
      end
      PAUSED: begin
        if (stop) begin
          w_nextState = IDLE;
        end else if (!pause) begin
          w_nextState = RUN;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Remaining-tick counter. period is captured only on an accepted start;
  // a zero period loads zero and goes straight to DONE. Ticks only occur in
  // RUN where remaining is at least 1, but the decrement is still guarded
  // so the count can never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (w_accept) begin
      r_remaining <= period;
    end else if (w_abort) begin
      r_remaining <= '0;
    end else if (w_tick && (r_remaining != '0)) begin
      r_remaining <= r_remaining - CNT_BITS'(1);
    end
  end

  // Outputs decoded from registered state, plus the combinational tick.
  always_comb begin
    busy      = w_active;
    done      = (r_state == DONE);
    tick      = w_tick;
    remaining = r_remaining;
  end

endmodule : interval_sequencer

// File: tb/tb_interval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interval_sequencer
// Self-checking bench for interval_sequencer with PRESCALE=4. Each cycle the
// outputs are compared against a behavioural model of the interval timer;
// directed scenarios add cycle-position checks on top.
// ---------------------------------------------------------------------------
module tb_interval_sequencer;

  localparam int PRESCALE = 4;
  localparam int PS_BITS  = 2;
  localparam int CNT_BITS = 8;

  logic                clk;
  logic                rst;
  logic                start;
  logic                stop;
  logic                pause;
  logic [CNT_BITS-1:0] period;
  logic                busy;
  logic                done;
  logic                tick;
  logic [CNT_BITS-1:0] remaining;

  int checkCount;
  int failCount;

  // Behavioural model: an interval is either not running, running, or
  // frozen; phase is how many enabled cycles have elapsed in the current
  // prescaler period; a pending done marks the one-cycle completion slot.
  bit mRunning;
  bit mFrozen;
  bit mDone;
  int mRemaining;
  int mPhase;

  // Values sampled from the DUT in the most recent step.
  logic                sBusy;
  logic                sDone;
  logic                sTick;
  logic [CNT_BITS-1:0] sRemaining;

  interval_sequencer #(
    .PRESCALE (PRESCALE),
    .PS_BITS  (PS_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .period    (period),
    .busy      (busy),
    .done      (done),
    .tick      (tick),
    .remaining (remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic modelAdvance(input bit r, input bit s, input bit st,
                              input bit p, input int per);
    if (r) begin
      mRunning = 0; mFrozen = 0; mDone = 0; mRemaining = 0; mPhase = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (!mRunning) begin
      if (s) begin
        if (per == 0) begin
          mDone = 1;
          mRemaining = 0;
        end else begin
          mRunning = 1; mFrozen = 0; mRemaining = per; mPhase = 0;
        end
      end
    end else if (st) begin
      mRunning = 0; mFrozen = 0; mRemaining = 0; mPhase = 0;
    end else if (mFrozen) begin
      if (!p) mFrozen = 0;
    end else if (p) begin
      mFrozen = 1;
    end else if (mPhase == PRESCALE - 1) begin
      mPhase = 0;
      mRemaining = mRemaining - 1;
      if (mRemaining == 0) begin
        mRunning = 0;
        mDone = 1;
      end
    end else begin
      mPhase = mPhase + 1;
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model just before
  // the edge, then advance the model and move past the edge.
  task automatic applyStimulus(input bit r, input bit s, input bit st,
                               input bit p, input int per);
    bit expTick;
    rst    = r;
    start  = s;
    stop   = st;
    pause  = p;
    period = CNT_BITS'(per);
    #2;
    sBusy      = busy;
    sDone      = done;
    sTick      = tick;
    sRemaining = remaining;
    expTick = mRunning && !mFrozen && !st && !p && (mPhase == PRESCALE - 1);
    checkOutput("busy", 32'(sBusy), 32'(mRunning));
    checkOutput("done", 32'(sDone), 32'(mDone));
    checkOutput("tick", 32'(sTick), 32'(expTick));
    checkOutput("remaining", 32'(sRemaining), 32'(mRemaining));
    modelAdvance(r, s, st, p, per);
    @(posedge clk);
    #1;
  endtask

  int ticks;
  int doneAt;
  int doneSeen;
  int busyCycles;
  int pausedTicks;

  initial begin
    checkCount = 0;
    failCount  = 0;
    mRunning = 0; mFrozen = 0; mDone = 0; mRemaining = 0; mPhase = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; period = '0;
    @(posedge clk);
    #1;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("resetBusy", 32'(sBusy), 32'd0);
    checkOutput("resetRemaining", 32'(sRemaining), 32'd0);

    // Basic timing: period 3.
    $display("[TB] basic timing");
    applyStimulus(0, 1, 0, 0, 3);
    ticks = 0; doneAt = -1; busyCycles = 0;
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      ticks += int'(sTick);
      busyCycles += int'(sBusy);
      if (sDone) doneAt = c;
      if (c == 4)  checkOutput("basicRemC4", 32'(sRemaining), 32'd3);
      if (c == 5)  checkOutput("basicRemC5", 32'(sRemaining), 32'd2);
      if (c == 12) checkOutput("basicTickC12", 32'(sTick), 32'd1);
    end
    checkOutput("basicTicks", 32'(ticks), 32'd3);
    checkOutput("basicDoneCycle", 32'(doneAt), 32'd13);
    checkOutput("basicBusyCycles", 32'(busyCycles), 32'd12);

    // Pause in cycles 2..5 of a period-2 run.
    $display("[TB] pause");
    applyStimulus(0, 1, 0, 0, 2);
    ticks = 0; pausedTicks = 0; doneSeen = 0;
    for (int c = 1; c <= 18; c++) begin
      applyStimulus(0, 0, 0, (c >= 2 && c <= 5), 0);
      ticks += int'(sTick);
      if (c >= 2 && c <= 6) pausedTicks += int'(sTick);
      doneSeen += int'(sDone);
    end
    checkOutput("pauseTicksWhilePaused", 32'(pausedTicks), 32'd0);
    checkOutput("pauseTicks", 32'(ticks), 32'd2);
    checkOutput("pauseDone", 32'(doneSeen), 32'd1);

    // Stop in cycle 6 of a period-5 run, then a fresh run.
    $display("[TB] stop");
    applyStimulus(0, 1, 0, 0, 5);
    doneSeen = 0;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(0, 0, (c == 6), 0, 0);
      doneSeen += int'(sDone);
      if (c == 6) checkOutput("stopTick", 32'(sTick), 32'd0);
      if (c == 7) begin
        checkOutput("stopBusyC7", 32'(sBusy), 32'd0);
        checkOutput("stopRemC7", 32'(sRemaining), 32'd0);
      end
    end
    checkOutput("stopNoDone", 32'(doneSeen), 32'd0);
    applyStimulus(0, 1, 0, 0, 2);
    doneAt = -1;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (sDone) doneAt = c;
    end
    checkOutput("restartDoneCycle", 32'(doneAt), 32'd9);

    // Zero period.
    $display("[TB] zero period");
    applyStimulus(0, 1, 0, 0, 0);
    ticks = 0; busyCycles = 0;
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (c == 1) checkOutput("zeroDoneC1", 32'(sDone), 32'd1);
      ticks += int'(sTick);
      busyCycles += int'(sBusy);
    end
    checkOutput("zeroTicks", 32'(ticks), 32'd0);
    checkOutput("zeroBusy", 32'(busyCycles), 32'd0);

    // Start re-asserted during RUN must not reload.
    $display("[TB] ignored start");
    applyStimulus(0, 1, 0, 0, 3);
    doneAt = -1;
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(0, (c == 3), 0, 0, (c == 3) ? 9 : 0);
      if (c == 4) checkOutput("ignStartRem", 32'(sRemaining), 32'd3);
      if (sDone) doneAt = c;
    end
    checkOutput("ignStartDoneCycle", 32'(doneAt), 32'd13);

    // Reset mid-run.
    $display("[TB] reset mid-run");
    applyStimulus(0, 1, 0, 0, 3);
    doneSeen = 0;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus((c == 5), 0, 0, 0, 0);
      if (c >= 6) doneSeen += int'(sDone);
      if (c == 6) begin
        checkOutput("rstBusy", 32'(sBusy), 32'd0);
        checkOutput("rstRem", 32'(sRemaining), 32'd0);
      end
    end
    checkOutput("rstNoDone", 32'(doneSeen), 32'd0);

    // Stop and pause together on a tick cycle.
    $display("[TB] simultaneous events");
    applyStimulus(0, 1, 0, 0, 3);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 0, (c == 4), (c == 4), 0);
      if (c == 4) checkOutput("stopPauseTick", 32'(sTick), 32'd0);
      if (c == 5) checkOutput("stopPauseIdle", 32'(sBusy), 32'd0);
    end

    // Pause alone on a tick cycle.
    applyStimulus(0, 1, 0, 0, 3);
    doneAt = -1;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(0, 0, 0, (c == 4), 0);
      if (c == 4) checkOutput("pauseOnTick", 32'(sTick), 32'd0);
      if (c == 5) checkOutput("pauseOnTickRem", 32'(sRemaining), 32'd3);
      if (sDone) doneAt = c;
    end
    checkOutput("pauseOnTickDone", 32'(doneAt), 32'd15);

    // Randomised traffic against the model.
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 6) == 0,
                    ($urandom % 25) == 0, ($urandom % 8) == 0,
                    int'($urandom % 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule : tb_interval_sequencer
